// File: rtl/rate_divider_pkg.sv
// rate_divider_pkg
//   Shared types and helpers for the clock-rate divider.
//   mode_t      : run-time operating mode of the divider.
//   half_count  : clock edges per half-period of the output square wave.
package rate_divider_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        STEP   = 2'd2,
        HOLD   = 2'd3
    } mode_t;

    function automatic int half_count(input int clk_hz, input int out_hz);
        return clk_hz / (2 * out_hz);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Registered rising-edge detector for an already-debounced level input.
//   clk_in : clock
//   rst    : synchronous active-high reset
//   d      : level input
//   rise   : one-cycle pulse, registered, on the edge after d goes 0->1
module rise_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/rate_divider.sv
// rate_divider
//   Divides clk_in down to a square wave clk_out and strobes tick for one
//   cycle on every clk_out rising edge. Modes: NORMAL, FAST (FAST_FACTOR
//   times faster), STEP (one pulse per step rising edge), HOLD (frozen).
//   clk_in  : system clock
//   rst     : synchronous active-high reset
//   en      : count enable (0 freezes everything but step edge tracking)
//   mode    : mode_t operating mode
//   step    : debounced level; each rising edge is one step request
//   clk_out : divided square wave, registered
//   tick    : one-cycle strobe coincident with clk_out rising, registered
module rate_divider
    import rate_divider_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int OUT_HZ      = 1,
    parameter int FAST_FACTOR = 10
) (
    input  logic  clk_in,
    input  logic  rst,
    input  logic  en,
    input  mode_t mode,
    input  logic  step,
    output logic  clk_out,
    output logic  tick
);

    localparam int HALF_N = half_count(CLK_HZ, OUT_HZ);
    localparam int HALF_F = (FAST_FACTOR < 1) ? 0 : HALF_N / FAST_FACTOR;
    localparam int CW     = (HALF_N > 1) ? $clog2(HALF_N) : 1;

    generate
        if (HALF_F < 1 || FAST_FACTOR < 1) begin : g_bad_params
            $error("rate_divider: HALF_F < 1 or FAST_FACTOR < 1");
        end
    endgenerate

    // Terminal values are stored as limit-1 so a power-of-two HALF_N still
    // fits in CW bits.
    localparam logic [CW-1:0] LIM_N_M1 = CW'(HALF_N - 1);
    localparam logic [CW-1:0] LIM_F_M1 = CW'(HALF_F - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] lim_m1;
    mode_t         mode_q;
    logic          step_rise;

    rise_detect u_step_rise (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (step),
        .rise   (step_rise)
    );

    assign lim_m1 = (mode_q == FAST) ? LIM_F_M1 : LIM_N_M1;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            mode_q  <= NORMAL;
        end else if (mode != mode_q) begin
            // Mode change wins over a coincident terminal count.
            mode_q <= mode;
            cnt    <= '0;
            tick   <= 1'b0;
            if (mode == STEP)
                clk_out <= 1'b0;
        end else begin
            unique case (mode_q)
                STEP: begin
                    cnt     <= '0;
                    clk_out <= step_rise & en;
                    tick    <= step_rise & en;
                end
                HOLD: begin
                    tick <= 1'b0;
                end
                default: begin
                    if (!en) begin
                        tick <= 1'b0;
                    end else if (cnt == lim_m1) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                        tick    <= ~clk_out;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        tick <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
